demux1_2_stream: RTL and testbench
==================================

DEMUX1_2_STREAM -- requirements
Module: demux1_2_stream

Interface
REQ-001 Parameter W, default 8: data width in bits, legal range 1..32.
REQ-002 Parameter DEPTH, default 2: entries per output buffer, fixed at 2 in this revision.
REQ-003 Port clk, input, 1: sole clock, rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port s, input, 1: route select, sampled with the input beat; 0 selects channel 0, 1 selects channel 1.
REQ-006 Port in_data, input, W: input beat payload.
REQ-007 Port in_valid, input, 1: input beat present.
REQ-008 Port in_ready, output, 1: block can accept the beat on the selected channel.
REQ-009 Ports out0_data and out1_data, output, W each: channel payloads.
REQ-010 Ports out0_valid and out1_valid, output, 1 each: channel beat present.
REQ-011 Ports out0_ready and out1_ready, input, 1 each: channel consumer accepts.
REQ-012 Ports cnt0 and cnt1, output, 16 each: per-channel delivered-beat counters, present only with DEMUX_CNT_EN.

Function
REQ-013 Input transfer occurs on a rising clk edge with in_valid=1 and in_ready=1.
REQ-014 in_ready is combinational: 1 when the buffer selected by s holds fewer than 2 entries; it does not depend on in_valid or on out*_ready.
REQ-015 A full buffer deasserts in_ready even if that buffer pops in the same cycle (no same-cycle pass-through).
REQ-016 An accepted beat appears on the selected channel no earlier than 1 cycle after acceptance (registered output); data never goes to the unselected channel.
REQ-017 Output transfer occurs on a rising edge with outN_valid=1 and outN_ready=1; outN_valid is 1 whenever buffer N holds at least 1 entry.
REQ-018 Per-channel order is preserved; the two channels are independent, so a stall on one never blocks beats routed to the other.
REQ-019 Simultaneous push and pop on a buffer holding 1 entry keeps the count at 1 and presents the new beat the following cycle.
REQ-020 outN_data and outN_valid are stable while outN_valid=1 and outN_ready=0.
REQ-021 Changing s while in_valid=1 and in_ready=0 is legal; the beat routes per s at the accepting edge.
REQ-022 Buffer state per channel: EMPTY (0), ONE (1), FULL (2); push-only increments, pop-only decrements, push+pop holds.

Reset
REQ-023 While rst=1: buffer counts are 0, out0_valid=out1_valid=0, out0_data=out1_data=0, and cnt0=cnt1=0 when present.
REQ-024 Reset asserted mid-transfer discards all buffered beats; there is no partial-beat recovery.
REQ-025 in_ready follows REQ-014 from the cleared state, so it is 1 during reset; the environment must not drive in_valid during reset.

Configuration
REQ-026 Macro DEMUX_CNT_EN: when defined, cnt0 and cnt1 exist and each increments by 1 per output transfer on its channel, wrapping from 0xFFFF to 0x0000.
REQ-027 When DEMUX_CNT_EN is undefined, the cnt0 and cnt1 ports and their logic are absent; all other behaviour is identical.

Structure
REQ-028 Package demux_pkg holds the channel enum (CH0=0, CH1=1), the buffer state enum (EMPTY, ONE, FULL) and the constant CNT_W=16.
REQ-029 Sub-module demux_obuf implements one 2-entry valid/ready buffer with a full flag; the top instantiates it twice and holds the routing logic and counters.

Verification
REQ-030 After reset, drive s=0, in_data=0xA5, in_valid=1 for 1 cycle with out0_ready=1: out0_valid=1 with 0xA5 the next cycle, out1_valid stays 0.
REQ-031 Hold out1_ready=0 and send 3 beats with s=1 (0x01, 0x02, 0x03): the first two are accepted, and in_ready=0 for the third until out1_ready=1; delivery order is 0x01, 0x02, 0x03.
REQ-032 With channel 1 full and stalled, send s=0 beats 0x10 and 0x11: both are accepted and delivered on out0 without waiting on channel 1.
REQ-033 Channel 0 holds 1 entry while a push and a pop occur in the same cycle: the count stays 1, and the popped value is the old beat with the new beat presented next.
REQ-034 Assert rst asynchronously with both buffers full: all valids drop immediately, and after release in_ready=1 with no stale beats.
REQ-035 With DEMUX_CNT_EN, deliver 65537 beats on channel 0: cnt0 reads 1 (wrap) and cnt1 reads 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:2 stream demultiplexer.
package demux_pkg;

    // Route select encoding
    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_e;

    // Output buffer fill level; the encoding doubles as the entry count
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/demux_obuf.sv
// Two-entry valid/ready output buffer. The head entry drives the output directly,
// so a pushed beat is visible no earlier than the cycle after acceptance.
module demux_obuf
    import demux_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    localparam logic [1:0] DEPTH_L = DEPTH[1:0];

    buf_state_e   state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   fill;
    logic         push;
    logic         pop;

    assign fill      = state_q;
    assign full      = (fill == DEPTH_L);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;

    // A full buffer refuses pushes even while popping: no same-cycle pass-through
    assign push = push_valid && !full;
    assign pop  = out_valid && out_ready;

    // Next-state: fill level and entry movement for push/pop combinations
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State and storage registers; reset discards all buffered beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/demux1_2_stream.sv
// 1:2 valid/ready stream demultiplexer with an independent 2-entry buffer per channel.
// Optional feature: define DEMUX_CNT_EN to add per-channel delivered-beat counters
// (cnt0/cnt1, wrapping at 16 bits).
module demux1_2_stream
    import demux_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [W-1:0]     out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    ch_e  sel;
    logic full0;
    logic full1;
    logic push0;
    logic push1;

    assign sel = ch_e'(s);

    // Ready depends only on the selected buffer's fill, never on in_valid or out*_ready
    always_comb begin
        in_ready = (sel == CH1) ? !full1 : !full0;
        push0    = in_valid && in_ready && (sel == CH0);
        push1    = in_valid && in_ready && (sel == CH1);
    end

    demux_obuf #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_obuf0 (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push0),
        .push_data  (in_data),
        .full       (full0),
        .out_valid  (out0_valid),
        .out_data   (out0_data),
        .out_ready  (out0_ready)
    );

    demux_obuf #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_obuf1 (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push1),
        .push_data  (in_data),
        .full       (full1),
        .out_valid  (out1_valid),
        .out_data   (out1_data),
        .out_ready  (out1_ready)
    );

`ifdef DEMUX_CNT_EN
    // Count output transfers per channel, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) cnt0 <= cnt0 + CNT_W'(1);
            if (out1_valid && out1_ready) cnt1 <= cnt1 + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux1_2_stream.sv
// Directed self-checking bench for demux1_2_stream (counter checks when DEMUX_CNT_EN is set).
module tb_demux1_2_stream;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         s;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out0_data;
    logic         out0_valid;
    logic         out0_ready;
    logic [W-1:0] out1_data;
    logic         out1_valid;
    logic         out1_ready;
`ifdef DEMUX_CNT_EN
    logic [15:0]  cnt0;
    logic [15:0]  cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    demux1_2_stream #(
        .W     (W),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (s),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        s          = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_v0", out0_valid, 0);
        check("rst_v1", out1_valid, 0);
        check("rst_d0", out0_data, 0);
        check("rst_d1", out1_data, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single beat on channel 0
        s = 1'b0; in_data = 8'hA5; in_valid = 1'b1; out0_ready = 1'b1;
        #1 check("a5_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("a5_v0", out0_valid, 1);
        check("a5_d0", out0_data, 8'hA5);
        check("a5_v1", out1_valid, 0);
        tick();
        check("a5_drained", out0_valid, 0);
        out0_ready = 1'b0;

        // Fill channel 1 while stalled
        s = 1'b1; in_data = 8'h01; in_valid = 1'b1;
        tick();
        in_data = 8'h02;
        tick();
        in_data = 8'h03;
        #1 check("ch1_full_ready", in_ready, 0);
        tick();
        check("ch1_stall_ready", in_ready, 0);
        check("ch1_stall_v", out1_valid, 1);
        check("ch1_stall_d", out1_data, 8'h01);

        // Channel 0 proceeds while channel 1 is stalled
        s = 1'b0; in_data = 8'h10;
        #1 check("ch0_indep_ready", in_ready, 1);
        tick();
        in_data = 8'h11;
        tick();
        in_valid = 1'b0;
        check("ch0_10_v", out0_valid, 1);
        check("ch0_10_d", out0_data, 8'h10);
        out0_ready = 1'b1;
        tick();
        check("ch0_11_d", out0_data, 8'h11);
        tick();
        check("ch0_empty", out0_valid, 0);
        out0_ready = 1'b0;
        check("ch1_still_v", out1_valid, 1);
        check("ch1_still_d", out1_data, 8'h01);

        // Release channel 1; full buffer stays not-ready in the popping cycle
        s = 1'b1; in_data = 8'h03; in_valid = 1'b1; out1_ready = 1'b1;
        #1 check("ch1_nopass", in_ready, 0);
        tick();
        check("ch1_d02", out1_data, 8'h02);
        check("ch1_ready_after_pop", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("ch1_d03_v", out1_valid, 1);
        check("ch1_d03", out1_data, 8'h03);
        tick();
        check("ch1_empty", out1_valid, 0);
        out1_ready = 1'b0;

        // Push and pop together on a one-entry channel 0
        s = 1'b0; in_data = 8'h20; in_valid = 1'b1;
        tick();
        in_data = 8'h21; out0_ready = 1'b1;
        #1 check("pp_old_d", out0_data, 8'h20);
        tick();
        in_valid = 1'b0; out0_ready = 1'b0;
        check("pp_v", out0_valid, 1);
        check("pp_new_d", out0_data, 8'h21);
        in_data = 8'h22; in_valid = 1'b1;
        #1 check("pp_count1_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("pp_now_full", in_ready, 0);

        // Fill channel 1, then reset asynchronously with both buffers full
        s = 1'b1; in_data = 8'h30; in_valid = 1'b1;
        tick();
        in_data = 8'h31;
        tick();
        in_valid = 1'b0;
        check("both_full_ready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_v0", out0_valid, 0);
        check("arst_v1", out1_valid, 0);
        check("arst_d0", out0_data, 0);
        check("arst_d1", out1_data, 0);
        tick();
        rst = 1'b0;
        #1 check("post_rst_ready1", in_ready, 1);
        s = 1'b0;
        #1 check("post_rst_ready0", in_ready, 1);
        tick();
        check("post_rst_v0", out0_valid, 0);
        check("post_rst_v1", out1_valid, 0);
        s = 1'b1; in_data = 8'h40; in_valid = 1'b1; out1_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_d1", out1_data, 8'h40);
        check("post_rst_v0b", out0_valid, 0);
        tick();
        check("post_rst_drain", out1_valid, 0);
        out1_ready = 1'b0;

`ifdef DEMUX_CNT_EN
        check("cnt1_one", cnt1, 1);
        #2 rst = 1'b1;
        #1 check("cnt0_rst", cnt0, 0);
        check("cnt1_rst", cnt1, 0);
        tick();
        rst = 1'b0;
        tick();
        // 65537 pushes; pops follow one cycle behind, so one extra edge drains the last
        s = 1'b0; in_data = 8'h55; in_valid = 1'b1; out0_ready = 1'b1;
        for (int i = 0; i < 65537; i++) tick();
        in_valid = 1'b0;
        tick();
        out0_ready = 1'b0;
        check("cnt0_wrap", cnt0, 1);
        check("cnt1_zero", cnt1, 0);
        check("cnt_drained", out0_valid, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
